// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_e;

  // Control bundle, MSB first: pc_en .. halted
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic halted;
  } ctrl_t;

  // A flushed buffer keeps its enable high so the cleared value loads.
  localparam ctrl_t CTRL_IDLE   = 8'b1101_0100;
  localparam ctrl_t CTRL_BRANCH = 8'b1111_1100;
  localparam ctrl_t CTRL_MD     = 8'b0000_0110;
  localparam ctrl_t CTRL_BUBBLE = 8'b0001_1100;
  localparam ctrl_t CTRL_HALTED = 8'b0000_0001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges load-use, branch redirect,
// multi-cycle mul/div and halt into per-stage enable/flush controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_CYCLES    = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_hz,
  input  logic              branch_taken,
  input  logic              muldiv_ex,
  input  logic              halt_req,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_en,
  output logic              ex_mem_flush,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cycles
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctrl_t            ctrl;

  // State and sequencing counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and outputs; RUN requests resolved in fixed priority
  always_comb begin
    ctrl      = CTRL_IDLE;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (muldiv_ex) begin
          // The entry cycle is the first of MD_CYCLES, the release the last
          ctrl      = CTRL_MD;
          cnt_nxt   = CNT_W'(MD_CYCLES - 2);
          state_nxt = MD_WAIT;
        end else if (load_use_hz) begin
          ctrl = CTRL_BUBBLE;
        end else if (halt_req) begin
          ctrl      = CTRL_BUBBLE;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          state_nxt = DRAIN;
        end
      end
      MD_WAIT: begin
        if (cnt != '0) begin
          ctrl    = CTRL_MD;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        ctrl = CTRL_BUBBLE;
        if (cnt != '0) cnt_nxt   = cnt - CNT_W'(1);
        else           state_nxt = HALTED;
      end
      HALTED: begin
        ctrl = CTRL_HALTED;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign halted       = ctrl.halted;

  // A halted core is idle, not stalled
  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctrl.pc_en && state != HALTED),
    .count (stall_cycles)
  );

endmodule
